reg_wb_arbiter: RTL and testbench
=================================

// Module: reg_wb_arbiter
// PURPOSE
//  Write-back controller in front of the 32x32 register bank. Arbitrates the bank's single write port
//  between the ALU and memory-load result paths (round-robin, valid/ready). Keeps a 32-bit pending-write
//  scoreboard that stalls decode on RAW and WAW hazards. Sits between the execute/load stages and the bank.
//  Drives the bank's write select/data ports directly.
// PARAMETERS
//  NREG     32   number of architectural registers (register 0 reads as zero, never written)
//  AW       5    register index width, log2(NREG)
//  DW       32   data width
//  RR_INIT  1    requester treated as last-granted at reset (0=ALU, 1=MEM); default lets ALU win first
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  alu_valid    in   1   ALU result available
//  alu_rd       in   AW  ALU destination register
//  alu_data     in   DW  ALU result
//  alu_ready    out  1   ALU result accepted this cycle
//  mem_valid    in   1   load result available
//  mem_rd       in   AW  load destination register
//  mem_data     in   DW  load result
//  mem_ready    out  1   load result accepted this cycle
//  issue_valid  in   1   decode issues an instruction that writes issue_rd
//  issue_rd     in   AW  destination of the issuing instruction
//  rs1_select   in   AW  decode source 1 (same index driven to the bank)
//  rs2_select   in   AW  decode source 2
//  stall        out  1   decode must hold: source or destination register has a pending write
//  wb_select    out  AW  to bank dataW_select
//  wb_data      out  DW  to bank dataW
//  wb_active    out  1   wb_select/wb_data carry a real write this cycle
//  err_waw      out  1   sticky: issue_valid seen while issue_rd was already pending
// BEHAVIOUR
//  Reset (async, rst_n=0): wb_select=0, wb_data=0, wb_active=0, scoreboard=0, err_waw=0,
//   last_grant=RR_INIT. alu_ready=mem_ready=0 while rst_n=0. A reset mid-write drops the in-flight write.
//  Idle bank port: the bank writes every edge and has no enable. When wb_active=0, drive wb_select=0 and
//   wb_data=0 (harmless write to r0).
//  Arbitration (combinational): only one valid -> grant it. Both valid -> grant the requester not in
//   last_grant. Neither -> no grant. x_ready = grant_x. Transfer = valid & ready. last_grant updates only
//   on a transfer. Requesters hold rd/data stable until ready.
//  Write stage (registered, 1 cycle): a transfer in cycle N -> wb_select/wb_data/wb_active present in
//   cycle N+1. The bank commits at the edge ending N+1. Back-to-back transfers give one write per cycle.
//  rd=0 transfer: accepted (ready=1); wb_select=0, wb_data=0, wb_active=0; scoreboard untouched.
//  Scoreboard: pending[r] is set at the edge ending a cycle with issue_valid=1 and issue_rd=r, r!=0.
//   It is cleared at the edge ending the cycle where wb_active=1 and wb_select=r, so it clears only
//   after the bank has committed. Set and clear on the same r in the same cycle: set wins.
//  stall = pending[rs1_select] | pending[rs2_select] | pending[issue_rd]; index 0 never stalls.
//   stall is combinational from registered state and current selects.
//  WAW violation: issue_valid while pending[issue_rd]=1 (r!=0). The bit stays set and err_waw sets;
//   err_waw is cleared only by reset.
//  No result without a pending bit is an error condition. The write still proceeds, and clearing an
//   already-clear bit is a no-op.
// STRUCTURE
//  Package reg_wb_pkg: AW, DW, NREG constants; requester id enum {REQ_ALU=0, REQ_MEM=1}.
//  Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], last_grant register, grant[1:0]).
//  Top level contains the write-stage register, the scoreboard vector, stall/err logic and the
//   rr_arb2 instance.
// TESTING
//  1 Reset: rst_n=0 mid-write with wb_active=1 -> all outputs 0 immediately, pending=0, no bank write next cycle.
//  2 Contention: alu_valid=mem_valid=1 for 4 cycles (RR_INIT=1) -> grants ALU,MEM,ALU,MEM; wb_active=1 for 4 cycles, each one cycle after its transfer.
//  3 Hazard: issue rd=5, then rs1_select=5 -> stall=1. ALU writes r5=0x70000001 -> stall drops the cycle after wb_active; next bank read of r5 = 0x70000001.
//  4 r0: mem_valid, mem_rd=0, mem_data=0xDEADBEEF -> mem_ready=1; wb_active=0, wb_select=0, wb_data=0.
//  5 Set/clear collision: wb of r3 in same cycle as issue rd=3 -> pending[3]=1 afterwards, stall on rs2_select=3.
//  6 WAW: issue rd=7 twice without write-back -> err_waw=1 and stays 1 until rst_n=0.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared widths and requester ids for the register write-back controller.
package reg_wb_pkg;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;
    typedef enum logic {REQ_ALU = 1'b0, REQ_MEM = 1'b1} req_id_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; last_grant advances only when something is granted.
module rr_arb2
    import reg_wb_pkg::*;
#(
    parameter req_id_e RR_INIT = REQ_MEM
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    req_id_e last_grant;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_grant <= RR_INIT;
        else if (|grant) last_grant <= grant[1] ? REQ_MEM : REQ_ALU;
    always_comb grant = &req ? (last_grant == REQ_MEM ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: arbitrates ALU/load results onto the bank write port and tracks pending writes
// so decode stalls on RAW/WAW hazards.
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter bit RR_INIT = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    input  logic [AW-1:0] rs1_select,
    input  logic [AW-1:0] rs2_select,
    output logic          stall,
    output logic [AW-1:0] wb_select,
    output logic [DW-1:0] wb_data,
    output logic          wb_active,
    output logic          err_waw
);
    localparam logic [NREG-1:0] ONE = NREG'(1);
    logic [1:0]      grant, gnt;
    logic [AW-1:0]   sel_d;
    logic [DW-1:0]   data_d;
    logic            act_d;
    logic [NREG-1:0] pending, set_mask, clr_mask;

    rr_arb2 #(.RR_INIT(req_id_e'(RR_INIT))) u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req  ({mem_valid, alu_valid}),
        .grant(grant)
    );

    // Readies are forced low while reset is held, even though the arbiter is combinational.
    assign gnt       = grant & {2{rst_n}};
    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign sel_d     = gnt[0] ? alu_rd : mem_rd;
    assign data_d    = gnt[0] ? alu_data : mem_data;
    assign act_d     = |gnt && sel_d != '0;

    // The bank writes every edge, so an idle port parks on a harmless r0 write.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wb_active <= 1'b0;
            wb_select <= '0;
            wb_data   <= '0;
        end else begin
            wb_active <= act_d;
            wb_select <= act_d ? sel_d : '0;
            wb_data   <= act_d ? data_d : '0;
        end

    assign set_mask = issue_valid && issue_rd != '0 ? ONE << issue_rd : '0;
    assign clr_mask = wb_active ? ONE << wb_select : '0;

    // Clear is applied before set so a same-cycle issue to the committing register keeps it pending.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pending <= '0;
            err_waw <= 1'b0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
            err_waw <= err_waw | (|(set_mask & pending));
        end

    assign stall = pending[rs1_select] | pending[rs2_select] | pending[issue_rd];
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: scoreboard bench; a reference model predicts grants and write-back entries,
// queued at transfer time and compared when the write stage presents them.
module tb_reg_wb_arbiter;
    import reg_wb_pkg::*;
    logic          clk = 1'b0, rst_n = 1'b0;
    logic          alu_valid = 1'b0, mem_valid = 1'b0, issue_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0, mem_rd = '0, issue_rd = '0, rs1_select = '0, rs2_select = '0;
    logic [DW-1:0] alu_data = '0, mem_data = '0;
    logic          alu_ready, mem_ready, stall, wb_active, err_waw;
    logic [AW-1:0] wb_select;
    logic [DW-1:0] wb_data;
    logic [DW-1:0] bank [NREG] = '{default: '0};

    typedef struct packed {
        logic          act;
        logic [AW-1:0] sel;
        logic [DW-1:0] data;
    } wb_t;
    wb_t           q[$];
    wb_t           e, n;
    logic          m_last = 1'b1, m_err = 1'b0;
    logic [1:0]    m_g = '0;
    logic [NREG-1:0] m_pend = '0;
    int            checks = 0, errors = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_select(rs1_select), .rs2_select(rs2_select), .stall(stall),
        .wb_select(wb_select), .wb_data(wb_data), .wb_active(wb_active), .err_waw(err_waw)
    );

    always @(posedge clk) if (wb_active) bank[wb_select] <= wb_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            q.push_back('0);
            m_last = 1'b1;
            m_pend = '0;
            m_err  = 1'b0;
            m_g    = '0;
        end else begin
            check("q_size", 64'(q.size()), 64'd1);
            e = q.size() != 0 ? q.pop_front() : '0;
            check("wb_active", wb_active, e.act);
            check("wb_select", wb_select, e.sel);
            check("wb_data", wb_data, e.data);
            check("stall", stall, m_pend[rs1_select] | m_pend[rs2_select] | m_pend[issue_rd]);
            check("err_waw", err_waw, m_err);
            m_g = alu_valid && mem_valid ? (m_last ? 2'b01 : 2'b10) : {mem_valid, alu_valid};
            check("alu_ready", alu_ready, m_g[0]);
            check("mem_ready", mem_ready, m_g[1]);
            if (|m_g) m_last = m_g[1];
            n.sel  = m_g[0] ? alu_rd : mem_rd;
            n.data = m_g[0] ? alu_data : mem_data;
            n.act  = |m_g && n.sel != '0;
            if (!n.act) n = '0;
            q.push_back(n);
            if (issue_valid && issue_rd != '0 && m_pend[issue_rd]) m_err = 1'b1;
            m_pend = (m_pend & ~(e.act ? NREG'(1) << e.sel : '0))
                   | (issue_valid && issue_rd != '0 ? NREG'(1) << issue_rd : '0);
        end
    end

    initial begin
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        check("rst_wb_active", wb_active, 0);
        check("rst_stall", stall, 0);
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA000_0000 + 32'((i + 1) / 2);
            mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hB000_0000 + 32'(i / 2);
            @(negedge clk);
            check("rr_alu", alu_ready, i % 2 == 0);
            check("rr_mem", mem_ready, i % 2 == 1);
            cyc();
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        check("rr_last_wb_act", wb_active, 1);
        check("rr_last_wb_sel", wb_select, 2);
        check("rr_last_wb_data", wb_data, 32'hB000_0001);
        cyc();
        issue_valid = 1'b1; issue_rd = 5'd5;
        cyc();
        issue_valid = 1'b0; issue_rd = '0; rs1_select = 5'd5;
        @(negedge clk);
        check("raw_stall", stall, 1);
        cyc();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h7000_0001;
        cyc();
        alu_valid = 1'b0;
        @(negedge clk);
        check("raw_wb", wb_active, 1);
        check("raw_stall_wb", stall, 1);
        cyc();
        @(negedge clk);
        check("raw_clear", stall, 0);
        check("raw_bank", bank[5], 32'h7000_0001);
        rs1_select = '0;
        cyc();
        mem_valid = 1'b1; mem_rd = '0; mem_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("r0_ready", mem_ready, 1);
        cyc();
        mem_valid = 1'b0;
        @(negedge clk);
        check("r0_act", wb_active, 0);
        check("r0_sel", wb_select, 0);
        check("r0_data", wb_data, 0);
        cyc();
        issue_valid = 1'b1; issue_rd = 5'd3;
        cyc();
        issue_valid = 1'b0; issue_rd = '0; alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        cyc();
        alu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd3;
        @(negedge clk);
        check("coll_wb", wb_active, 1);
        cyc();
        issue_valid = 1'b0; issue_rd = '0; rs2_select = 5'd3;
        @(negedge clk);
        check("coll_stall", stall, 1);
        cyc();
        check("coll_stall_hold", stall, 1);
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h4444;
        cyc();
        #1;
        check("mid_wb_act", wb_active, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_act", wb_active, 0);
        check("mid_rst_sel", wb_select, 0);
        check("mid_rst_data", wb_data, 0);
        check("mid_rst_ready", alu_ready, 0);
        check("mid_rst_err", err_waw, 0);
        alu_valid = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_pend", stall, 0);
        check("rst_bank4", bank[4], 0);
        rs2_select = '0;
        cyc();
        issue_valid = 1'b1; issue_rd = 5'd7;
        cyc();
        cyc();
        issue_valid = 1'b0; issue_rd = '0;
        @(negedge clk);
        check("waw_err", err_waw, 1);
        repeat (5) cyc();
        check("waw_sticky", err_waw, 1);
        rst_n = 1'b0;
        #1;
        check("waw_rst", err_waw, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 200; i++) begin
            if (!alu_valid || m_g[0]) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_rd    = AW'($urandom_range(0, NREG - 1));
                alu_data  = $urandom;
            end
            if (!mem_valid || m_g[1]) begin
                mem_valid = 1'($urandom_range(0, 1));
                mem_rd    = AW'($urandom_range(0, NREG - 1));
                mem_data  = $urandom;
            end
            issue_valid = $urandom_range(0, 3) == 0;
            issue_rd    = AW'($urandom_range(0, NREG - 1));
            rs1_select  = AW'($urandom_range(0, NREG - 1));
            rs2_select  = AW'($urandom_range(0, NREG - 1));
            cyc();
        end
        alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
